instr_queue: RTL and testbench
==============================

// Module: instr_queue
// PURPOSE
//  Circular instruction FIFO between instr_fetch_unit (producer) and decode/dispatch (consumer).
//  Tracks entries written after the one outstanding predicted branch as speculative.
//  Speculative entries are held from dispatch until the branch resolves, then released (correct)
//  or squashed by rolling back the write pointer (mispredict). Drives iq_full back to fetch.
// PARAMETERS
//  DEPTH      8   entries; power of two, >= 2
//  PTR_W      $clog2(DEPTH)   derived, not overridable
// PORTS
//  clk_i             in   1        clock; all state updates on posedge
//  reset_i           in   1        synchronous, active-high reset
//  iq_write_i        in   1        fetch writes instr_i this cycle
//  instr_i           in   32       word32_t instruction from fetch
//  issuing_branch_i  in   1        written entry is a predicted branch (qualifies iq_write_i)
//  cond_eval_i       in   1        branch ALU resolved the outstanding branch this cycle
//  corr_pred_i       in   1        prediction correct; valid only with cond_eval_i
//  iq_full_o         out  1        count == DEPTH
//  deq_valid_o       out  1        head entry present and non-speculative
//  deq_ready_i       in   1        consumer accepts head; pop when deq_valid_o & deq_ready_i
//  instr_o           out  32       head instruction (word32_t)
//  count_o           out  PTR_W+1  occupied entries, speculative included
// BEHAVIOUR
//  - Reset: rd/wr pointers 0, all spec bits 0, spec_active 0; iq_full_o=0, deq_valid_o=0, count_o=0;
//    instr_o don't-care. Reset mid-operation discards all entries in one cycle.
//  - Pointers PTR_W+1 bits (wrap bit); count = wr_ptr - rd_ptr; full when MSBs differ, low bits equal.
//  - Write: when iq_write_i & ~iq_full_o & ~mispredict, store instr_i at wr_ptr, wr_ptr+1.
//    Write while full is dropped (assertion fires). Entry spec bit = spec_active (after update below).
//  - Branch entry itself is never speculative. On a branch write: checkpoint <= wr_ptr+1, spec_active<=1.
//  - Resolve correct (cond_eval_i & corr_pred_i): clear all spec bits, spec_active<=0; same-cycle
//    dequeue of previously held head allowed next cycle. If a new branch is written the same
//    cycle, clearing applies first, then the new checkpoint/spec_active<=1 is taken.
//  - Mispredict (cond_eval_i & ~corr_pred_i): wr_ptr <= checkpoint, spec bits cleared,
//    spec_active<=0; any same-cycle write is dropped. A same-cycle pop of a non-spec head proceeds.
//  - cond_eval_i with spec_active=0 is ignored (assertion fires).
//  - Read: deq_valid_o = ~empty & ~spec[rd_idx]; instr_o = mem[rd_idx] combinationally (0-cycle
//    read); pop advances rd_ptr. Simultaneous push and pop when full: push dropped (full is
//    registered state), pop proceeds. Push and pop when not full: count unchanged.
//  - Latency: write at cycle N visible on deq_valid_o at N+1 (if non-spec). iq_full_o registered-state based.
//  - One outstanding branch max; fetch guarantees no second branch write while spec_active unless
//    resolve-correct is asserted the same cycle.
// STRUCTURE
//  - data_types pkg: word32_t (existing); add localparam IQ_DEPTH_DEFAULT=8 and
//    typedef struct packed {logic spec; word32_t instr;} iq_entry_t.
//  - Single module; storage as iq_entry_t array, no sub-modules. Spec clear done per-bit in one
//    always_ff; pointer/checkpoint logic in a separate always_comb next-state block.
// TESTING
//  1 Reset then 8 writes 0x00000013.. no pops -> iq_full_o=1, count_o=8; 9th write dropped, count stays 8.
//  2 Fill 8, pop 8 with deq_ready_i=1 -> instr_o order matches writes, pointers wrap, count_o=0, deq_valid_o=0.
//  3 Write branch 0x00C00063 then 3 ALU instrs, no resolve -> branch dequeues, deq_valid_o=0 after;
//    cond_eval_i=1,corr_pred_i=1 -> next cycle 3 instrs dequeue in order.
//  4 Same as 3 but corr_pred_i=0 -> count_o drops by 3, wr_ptr=checkpoint; next write lands right after branch slot.
//  5 Resolve-correct and new branch write same cycle, then 2 writes, then mispredict -> only the
//    2 later writes squashed; entries before new branch dispatch.
//  6 Mispredict with concurrent iq_write_i and pop -> write dropped, pop occurs; reset_i mid-fill -> count_o=0 next cycle.

Source files
------------

// File: rtl/instr_queue_pkg.sv
// ---------------------------------------------------------------------------
// instr_queue_pkg
// Shared types for the instruction queue slice.
//   word32_t          : 32-bit instruction word passed from fetch to decode
//   IQ_DEPTH_DEFAULT  : default number of queue entries
//   iq_entry_t        : one queue slot, speculative flag plus instruction
// ---------------------------------------------------------------------------
package instr_queue_pkg;

    typedef logic [31:0] word32_t;

    localparam int IQ_DEPTH_DEFAULT = 8;

    typedef struct packed {
        logic    spec;
        word32_t instr;
    } iq_entry_t;

endpackage : instr_queue_pkg

// File: rtl/instr_queue.sv
// ---------------------------------------------------------------------------
// instr_queue
// Circular instruction FIFO between the fetch unit and decode/dispatch.
// Entries written after the single outstanding predicted branch are marked
// speculative and held at the head until the branch resolves. A correct
// prediction releases them; a mispredict squashes them by rolling the write
// pointer back to the slot right after the branch.
//
// Ports
//   clk_i            in   clock, all state changes on posedge
//   reset_i          in   synchronous active-high reset
//   iq_write_i       in   fetch writes instr_i this cycle
//   instr_i          in   instruction from fetch
//   issuing_branch_i in   the written entry is a predicted branch
//   cond_eval_i      in   outstanding branch resolved this cycle
//   corr_pred_i      in   prediction was correct (valid with cond_eval_i)
//   iq_full_o        out  queue holds DEPTH entries
//   deq_valid_o      out  head entry present and non-speculative
//   deq_ready_i      in   consumer takes the head this cycle
//   instr_o          out  head instruction (combinational read)
//   count_o          out  occupied entries, speculative ones included
// ---------------------------------------------------------------------------
module instr_queue
    import instr_queue_pkg::*;
#(
    parameter int DEPTH = IQ_DEPTH_DEFAULT
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     iq_write_i,
    input  word32_t                  instr_i,
    input  logic                     issuing_branch_i,
    input  logic                     cond_eval_i,
    input  logic                     corr_pred_i,
    output logic                     iq_full_o,
    output logic                     deq_valid_o,
    input  logic                     deq_ready_i,
    output word32_t                  instr_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    iq_entry_t        r_mem [DEPTH];
    logic [PTR_W:0]   r_wrPtr;
    logic [PTR_W:0]   r_rdPtr;
    logic [PTR_W:0]   r_checkpoint;
    logic             r_specActive;

    logic [PTR_W:0]   w_wrPtrNext;
    logic [PTR_W:0]   w_rdPtrNext;
    logic [PTR_W:0]   w_checkpointNext;
    logic             w_specActiveNext;

    logic [PTR_W-1:0] w_wrIdx;
    logic [PTR_W-1:0] w_rdIdx;
    logic [PTR_W:0]   w_count;
    logic             w_empty;
    logic             w_full;
    logic             w_resolveCorrect;
    logic             w_mispredict;
    logic             w_clearSpec;
    logic             w_push;
    logic             w_pop;
    logic             w_entrySpec;

    assign w_wrIdx = r_wrPtr[PTR_W-1:0];
    assign w_rdIdx = r_rdPtr[PTR_W-1:0];
    assign w_count = r_wrPtr - r_rdPtr;
    assign w_empty = (r_wrPtr == r_rdPtr);
    // Extra wrap bit distinguishes full from empty when the indices match.
    assign w_full  = (r_wrPtr[PTR_W] != r_rdPtr[PTR_W]) &&
                     (r_wrPtr[PTR_W-1:0] == r_rdPtr[PTR_W-1:0]);

    // A resolve with no branch outstanding is meaningless and ignored.
    assign w_resolveCorrect = cond_eval_i &  corr_pred_i & r_specActive;
    assign w_mispredict     = cond_eval_i & ~corr_pred_i & r_specActive;
    assign w_clearSpec      = w_resolveCorrect | w_mispredict;

    // A mispredict squashes everything after the branch, including a
    // write arriving in the same cycle.
    assign w_push = iq_write_i & ~w_full & ~w_mispredict;
    assign w_pop  = deq_valid_o & deq_ready_i;

    // The branch itself dispatches freely; other writes inherit the
    // speculative state as it stands after a same-cycle correct resolve.
    assign w_entrySpec = ~issuing_branch_i & r_specActive & ~w_resolveCorrect;

    assign deq_valid_o = ~w_empty & ~r_mem[w_rdIdx].spec;
    assign instr_o     = r_mem[w_rdIdx].instr;
    assign iq_full_o   = w_full;
    assign count_o     = w_count;

    // Pointer, checkpoint and speculation next-state. Clearing on resolve
    // is applied before a new branch write so the new checkpoint wins.
    always_comb begin
        w_wrPtrNext      = r_wrPtr;
        w_rdPtrNext      = r_rdPtr;
        w_checkpointNext = r_checkpoint;
        w_specActiveNext = r_specActive;

        if (w_clearSpec) begin
            w_specActiveNext = 1'b0;
        end

        if (w_mispredict) begin
            w_wrPtrNext = r_checkpoint;
        end else if (w_push) begin
            w_wrPtrNext = r_wrPtr + 1'b1;
            if (issuing_branch_i) begin
                w_checkpointNext = r_wrPtr + 1'b1;
                w_specActiveNext = 1'b1;
            end
        end

        if (w_pop) begin
            w_rdPtrNext = r_rdPtr + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_wrPtr      <= '0;
            r_rdPtr      <= '0;
            r_checkpoint <= '0;
            r_specActive <= 1'b0;
        end else begin
            r_wrPtr      <= w_wrPtrNext;
            r_rdPtr      <= w_rdPtrNext;
            r_checkpoint <= w_checkpointNext;
            r_specActive <= w_specActiveNext;
        end
    end

    // Storage. Only the spec flags are reset; instruction words are
    // don't-care until written. A resolve clears every flag, then the
    // entry written this cycle takes its own flag.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i].spec <= 1'b0;
            end
        end else begin
            if (w_clearSpec) begin
                for (int i = 0; i < DEPTH; i++) begin
                    r_mem[i].spec <= 1'b0;
                end
            end
            if (w_push) begin
                r_mem[w_wrIdx].spec  <= w_entrySpec;
                r_mem[w_wrIdx].instr <= instr_i;
            end
        end
    end

`ifndef SYNTHESIS
    // Overflowing writes are tolerated (dropped) but worth flagging;
    // a resolve without an outstanding branch is a protocol error.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!(iq_write_i && w_full))
                else $warning("instr_queue: write while full dropped");
            assert (!(cond_eval_i && !r_specActive))
                else $error("instr_queue: resolve with no outstanding branch");
        end
    end
`endif

endmodule : instr_queue

// File: tb/tb_instr_queue.sv
// ---------------------------------------------------------------------------
// tb_instr_queue
// Directed self-checking bench for instr_queue. Each scenario task drives
// its own stimulus and compares outputs against hand-computed values.
// Inputs change #1 after the rising edge; outputs are checked there too.
// ---------------------------------------------------------------------------
module tb_instr_queue;

    logic        clock;
    logic        reset_i;
    logic        iq_write_i;
    logic [31:0] instr_i;
    logic        issuing_branch_i;
    logic        cond_eval_i;
    logic        corr_pred_i;
    logic        iq_full_o;
    logic        deq_valid_o;
    logic        deq_ready_i;
    logic [31:0] instr_o;
    logic [3:0]  count_o;

    int checkCount = 0;
    int passCount  = 0;

    localparam logic [31:0] BR   = 32'h00C00063;
    localparam logic [31:0] ALU1 = 32'h00100093;
    localparam logic [31:0] ALU2 = 32'h00200113;
    localparam logic [31:0] ALU3 = 32'h00300193;

    instr_queue dut (
        .clk_i            (clock),
        .reset_i          (reset_i),
        .iq_write_i       (iq_write_i),
        .instr_i          (instr_i),
        .issuing_branch_i (issuing_branch_i),
        .cond_eval_i      (cond_eval_i),
        .corr_pred_i      (corr_pred_i),
        .iq_full_o        (iq_full_o),
        .deq_valid_o      (deq_valid_o),
        .deq_ready_i      (deq_ready_i),
        .instr_o          (instr_o),
        .count_o          (count_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one cycle and settle just after the rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        iq_write_i       = 1'b0;
        instr_i          = 32'h0;
        issuing_branch_i = 1'b0;
        cond_eval_i      = 1'b0;
        corr_pred_i      = 1'b0;
        deq_ready_i      = 1'b0;
    endtask

    task automatic write(input logic [31:0] word, input logic isBranch);
        idle();
        iq_write_i       = 1'b1;
        instr_i          = word;
        issuing_branch_i = isBranch;
        tick();
        idle();
    endtask

    task automatic test_reset();
        idle();
        reset_i = 1'b1;
        tick();
        tick();
        reset_i = 1'b0;
        checkCount++;
        if (count_o !== 4'd0) $display("[TB] FAIL reset_count: got %0d expected 0", count_o);
        else passCount++;
        checkCount++;
        if (iq_full_o !== 1'b0) $display("[TB] FAIL reset_full: got %b expected 0", iq_full_o);
        else passCount++;
        checkCount++;
        if (deq_valid_o !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", deq_valid_o);
        else passCount++;
    endtask

    // Fill to capacity, try an overflow write, then drain while the first
    // drain cycle also attempts a (dropped) push against the full queue.
    task automatic test_fill_drain();
        for (int i = 0; i < 8; i++) write(32'h00000013 + 32'h100 * i, 1'b0);
        checkCount++;
        if (count_o !== 4'd8) $display("[TB] FAIL fill_count: got %0d expected 8", count_o);
        else passCount++;
        checkCount++;
        if (iq_full_o !== 1'b1) $display("[TB] FAIL fill_full: got %b expected 1", iq_full_o);
        else passCount++;

        write(32'hDEADBEEF, 1'b0);
        checkCount++;
        if (count_o !== 4'd8) $display("[TB] FAIL overflow_count: got %0d expected 8", count_o);
        else passCount++;
        checkCount++;
        if (instr_o !== 32'h00000013) $display("[TB] FAIL overflow_head: got %h expected 00000013", instr_o);
        else passCount++;

        for (int i = 0; i < 8; i++) begin
            idle();
            deq_ready_i = 1'b1;
            if (i == 0) begin
                iq_write_i = 1'b1;
                instr_i    = 32'hDEADBEEF;
            end
            checkCount++;
            if (deq_valid_o !== 1'b1 || instr_o !== 32'h00000013 + 32'h100 * i)
                $display("[TB] FAIL drain_%0d: got valid=%b instr=%h expected valid=1 instr=%h",
                         i, deq_valid_o, instr_o, 32'h00000013 + 32'h100 * i);
            else passCount++;
            tick();
            if (i == 0) begin
                checkCount++;
                if (count_o !== 4'd7) $display("[TB] FAIL full_push_pop_count: got %0d expected 7", count_o);
                else passCount++;
            end
        end
        idle();
        checkCount++;
        if (count_o !== 4'd0 || deq_valid_o !== 1'b0 || iq_full_o !== 1'b0)
            $display("[TB] FAIL drained: got count=%0d valid=%b full=%b expected 0/0/0",
                     count_o, deq_valid_o, iq_full_o);
        else passCount++;
    endtask

    task automatic test_branch_correct();
        write(BR, 1'b1);
        write(ALU1, 1'b0);
        write(ALU2, 1'b0);
        write(ALU3, 1'b0);
        checkCount++;
        if (count_o !== 4'd4 || deq_valid_o !== 1'b1 || instr_o !== BR)
            $display("[TB] FAIL bc_head: got count=%0d valid=%b instr=%h expected 4/1/%h",
                     count_o, deq_valid_o, instr_o, BR);
        else passCount++;

        deq_ready_i = 1'b1;
        tick();
        checkCount++;
        if (count_o !== 4'd3 || deq_valid_o !== 1'b0)
            $display("[TB] FAIL bc_held: got count=%0d valid=%b expected 3/0", count_o, deq_valid_o);
        else passCount++;
        tick();
        checkCount++;
        if (count_o !== 4'd3) $display("[TB] FAIL bc_still_held: got %0d expected 3", count_o);
        else passCount++;

        cond_eval_i = 1'b1;
        corr_pred_i = 1'b1;
        tick();
        cond_eval_i = 1'b0;
        corr_pred_i = 1'b0;
        checkCount++;
        if (deq_valid_o !== 1'b1 || instr_o !== ALU1)
            $display("[TB] FAIL bc_release: got valid=%b instr=%h expected 1/%h", deq_valid_o, instr_o, ALU1);
        else passCount++;
        tick();
        checkCount++;
        if (deq_valid_o !== 1'b1 || instr_o !== ALU2)
            $display("[TB] FAIL bc_order2: got valid=%b instr=%h expected 1/%h", deq_valid_o, instr_o, ALU2);
        else passCount++;
        tick();
        checkCount++;
        if (deq_valid_o !== 1'b1 || instr_o !== ALU3)
            $display("[TB] FAIL bc_order3: got valid=%b instr=%h expected 1/%h", deq_valid_o, instr_o, ALU3);
        else passCount++;
        tick();
        idle();
        checkCount++;
        if (count_o !== 4'd0) $display("[TB] FAIL bc_empty: got %0d expected 0", count_o);
        else passCount++;
    endtask

    task automatic test_branch_mispredict();
        write(BR, 1'b1);
        write(ALU1, 1'b0);
        write(ALU2, 1'b0);
        write(ALU3, 1'b0);
        cond_eval_i = 1'b1;
        corr_pred_i = 1'b0;
        tick();
        idle();
        checkCount++;
        if (count_o !== 4'd1 || deq_valid_o !== 1'b1 || instr_o !== BR)
            $display("[TB] FAIL mp_squash: got count=%0d valid=%b instr=%h expected 1/1/%h",
                     count_o, deq_valid_o, instr_o, BR);
        else passCount++;

        write(32'h00400213, 1'b0);
        checkCount++;
        if (count_o !== 4'd2) $display("[TB] FAIL mp_rewrite_count: got %0d expected 2", count_o);
        else passCount++;
        deq_ready_i = 1'b1;
        tick();
        checkCount++;
        if (deq_valid_o !== 1'b1 || instr_o !== 32'h00400213)
            $display("[TB] FAIL mp_after_branch: got valid=%b instr=%h expected 1/00400213",
                     deq_valid_o, instr_o);
        else passCount++;
        tick();
        idle();
        checkCount++;
        if (count_o !== 4'd0) $display("[TB] FAIL mp_empty: got %0d expected 0", count_o);
        else passCount++;
    endtask

    // Resolve-correct of the first branch coincides with writing a second.
    task automatic test_resolve_new_branch();
        write(BR, 1'b1);
        write(32'h00500293, 1'b0);
        idle();
        iq_write_i       = 1'b1;
        instr_i          = 32'h00800463;
        issuing_branch_i = 1'b1;
        cond_eval_i      = 1'b1;
        corr_pred_i      = 1'b1;
        tick();
        idle();
        write(32'h00600313, 1'b0);
        write(32'h00700393, 1'b0);
        checkCount++;
        if (count_o !== 4'd5) $display("[TB] FAIL rn_count: got %0d expected 5", count_o);
        else passCount++;

        cond_eval_i = 1'b1;
        corr_pred_i = 1'b0;
        tick();
        idle();
        checkCount++;
        if (count_o !== 4'd3) $display("[TB] FAIL rn_squash: got %0d expected 3", count_o);
        else passCount++;

        deq_ready_i = 1'b1;
        checkCount++;
        if (deq_valid_o !== 1'b1 || instr_o !== BR)
            $display("[TB] FAIL rn_pop0: got valid=%b instr=%h expected 1/%h", deq_valid_o, instr_o, BR);
        else passCount++;
        tick();
        checkCount++;
        if (deq_valid_o !== 1'b1 || instr_o !== 32'h00500293)
            $display("[TB] FAIL rn_pop1: got valid=%b instr=%h expected 1/00500293", deq_valid_o, instr_o);
        else passCount++;
        tick();
        checkCount++;
        if (deq_valid_o !== 1'b1 || instr_o !== 32'h00800463)
            $display("[TB] FAIL rn_pop2: got valid=%b instr=%h expected 1/00800463", deq_valid_o, instr_o);
        else passCount++;
        tick();
        idle();
        checkCount++;
        if (count_o !== 4'd0 || deq_valid_o !== 1'b0)
            $display("[TB] FAIL rn_empty: got count=%0d valid=%b expected 0/0", count_o, deq_valid_o);
        else passCount++;
    endtask

    task automatic test_mispredict_write_pop();
        write(BR, 1'b1);
        write(32'h00900493, 1'b0);
        idle();
        cond_eval_i = 1'b1;
        corr_pred_i = 1'b0;
        iq_write_i  = 1'b1;
        instr_i     = 32'hBAD00013;
        deq_ready_i = 1'b1;
        checkCount++;
        if (deq_valid_o !== 1'b1 || instr_o !== BR)
            $display("[TB] FAIL mwp_head: got valid=%b instr=%h expected 1/%h", deq_valid_o, instr_o, BR);
        else passCount++;
        tick();
        idle();
        checkCount++;
        if (count_o !== 4'd0 || deq_valid_o !== 1'b0)
            $display("[TB] FAIL mwp_result: got count=%0d valid=%b expected 0/0", count_o, deq_valid_o);
        else passCount++;

        // Push and pop together on a non-full queue keep the count.
        write(32'h00A00513, 1'b0);
        iq_write_i  = 1'b1;
        instr_i     = 32'h00B00593;
        deq_ready_i = 1'b1;
        tick();
        idle();
        checkCount++;
        if (count_o !== 4'd1 || instr_o !== 32'h00B00593)
            $display("[TB] FAIL push_pop: got count=%0d instr=%h expected 1/00B00593", count_o, instr_o);
        else passCount++;
    endtask

    task automatic test_reset_mid_fill();
        write(32'h00C00613, 1'b0);
        write(32'h00D00693, 1'b1);
        write(32'h00E00713, 1'b0);
        checkCount++;
        if (count_o !== 4'd4) $display("[TB] FAIL pre_reset_count: got %0d expected 4", count_o);
        else passCount++;
        iq_write_i = 1'b1;
        instr_i    = 32'h00F00793;
        reset_i    = 1'b1;
        tick();
        reset_i = 1'b0;
        idle();
        checkCount++;
        if (count_o !== 4'd0 || deq_valid_o !== 1'b0 || iq_full_o !== 1'b0)
            $display("[TB] FAIL mid_reset: got count=%0d valid=%b full=%b expected 0/0/0",
                     count_o, deq_valid_o, iq_full_o);
        else passCount++;
        // A write right after reset must not be held as speculative.
        write(32'h01000813, 1'b0);
        checkCount++;
        if (deq_valid_o !== 1'b1 || instr_o !== 32'h01000813)
            $display("[TB] FAIL post_reset_write: got valid=%b instr=%h expected 1/01000813",
                     deq_valid_o, instr_o);
        else passCount++;
    endtask

    initial begin
        reset_i = 1'b1;
        idle();
        #1;
        test_reset();
        test_fill_drain();
        test_branch_correct();
        test_branch_mispredict();
        test_resolve_new_branch();
        test_mispredict_write_pop();
        test_reset_mid_fill();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule : tb_instr_queue
